// File: rtl/vga_pkg.sv
// Shared VGA timing constants, types and the test-bar colour table
// used by vga_timing_gen and its alignment delay.
package vga_pkg;

  // 640x480@60 timing (pixels / lines)
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Which 80-pixel bar a horizontal position falls in (0..7)
  function automatic logic [2:0] bar_index(input coord_t x);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x >= coord_t'(80 * i)) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

  // Colour bar table: white, yellow, cyan, green, magenta, red, blue, black
  function automatic rgb_t bar_color(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = {8'hFF, 8'hFF, 8'hFF};
      3'd1:    c = {8'hFF, 8'hFF, 8'h00};
      3'd2:    c = {8'h00, 8'hFF, 8'hFF};
      3'd3:    c = {8'h00, 8'hFF, 8'h00};
      3'd4:    c = {8'hFF, 8'h00, 8'hFF};
      3'd5:    c = {8'hFF, 8'h00, 8'h00};
      3'd6:    c = {8'h00, 8'h00, 8'hFF};
      default: c = {8'h00, 8'h00, 8'h00};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Clock-enabled shift register used to align sync/blank (and pattern X)
// with the returned RGB. DEPTH=0 is a plain wire.
module vga_sync_delay #(
  parameter int               DEPTH   = 0,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_s;
      assign unused_s = ^{clk, rst, ce};
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_r [DEPTH];

      // Shift one stage per pixel strobe; reset loads the inactive value
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= RST_VAL;
          end
        end else if (ce) begin
          stage_r[0] <= din;
          for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
          end
        end
      end

      assign dout = stage_r[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA 640x480@60 timing generator: pixel divider, DrawX/DrawY counters,
// sync/blank generation, latency-matched RGB output registers and a
// once-per-frame tick. Define VGA_TEST_PATTERN_EN to add the test_pattern
// input selecting built-in colour bars instead of Red_in/Green_in/Blue_in.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK,
  parameter int PIX_DIV   = 2,
  parameter int PIPE_LAT  = 0
) (
  input  logic       Clk,
  input  logic       Reset,
`ifdef VGA_TEST_PATTERN_EN
  input  logic       test_pattern,
`endif
  input  logic [7:0] Red_in,
  input  logic [7:0] Green_in,
  input  logic [7:0] Blue_in,
  output logic       pix_ce,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_tick,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  localparam int H_TOT    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_nxt_s;
  logic             div_last_s;
  logic             pix_ce_r;
  logic             vga_clk_r;
  logic             frame_tick_r;
  coord_t           x_r;
  coord_t           y_r;
  logic             x_last_s;
  logic             y_last_s;
  logic             hs_raw_s;
  logic             vs_raw_s;
  logic             blank_raw_s;
  logic             hs_d_s;
  logic             vs_d_s;
  logic             blank_d_s;
  logic             hs_r;
  logic             vs_r;
  logic             blank_r;
  rgb_t             rgb_src_s;
  rgb_t             rgb_r;

  assign div_last_s = (div_r == DIV_W'(PIX_DIV - 1));
  assign x_last_s   = (x_r == coord_t'(H_TOT - 1));
  assign y_last_s   = (y_r == coord_t'(V_TOT - 1));

  // Next divider value, wrapping at PIX_DIV-1
  always_comb begin
    if (div_last_s) begin
      div_nxt_s = {DIV_W{1'b0}};
    end else begin
      div_nxt_s = div_r + DIV_W'(1);
    end
  end

  // Pixel divider, strobe, DAC clock (high in the second half of a pixel) and frame tick
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div_r        <= {DIV_W{1'b0}};
      pix_ce_r     <= 1'b0;
      vga_clk_r    <= 1'b0;
      frame_tick_r <= 1'b0;
    end else begin
      div_r        <= div_nxt_s;
      pix_ce_r     <= div_last_s;
      vga_clk_r    <= (div_nxt_s >= DIV_W'(PIX_DIV / 2));
      frame_tick_r <= div_last_s && x_last_s && (y_r == coord_t'(V_VISIBLE - 1));
    end
  end

  // Raster counters advance once per pixel strobe
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      x_r <= 10'd0;
      y_r <= 10'd0;
    end else if (pix_ce_r) begin
      if (x_last_s) begin
        x_r <= 10'd0;
        if (y_last_s) begin
          y_r <= 10'd0;
        end else begin
          y_r <= y_r + 10'd1;
        end
      end else begin
        x_r <= x_r + 10'd1;
      end
    end
  end

  // Undelayed sync/blank decoded from the current raster position
  always_comb begin
    hs_raw_s    = ~((x_r >= coord_t'(HS_START)) && (x_r < coord_t'(HS_END)));
    vs_raw_s    = ~((y_r >= coord_t'(VS_START)) && (y_r < coord_t'(VS_END)));
    blank_raw_s = (x_r < coord_t'(H_VISIBLE)) && (y_r < coord_t'(V_VISIBLE));
  end

  vga_sync_delay #(
    .DEPTH  (PIPE_LAT),
    .WIDTH  (3),
    .RST_VAL(3'b110)
  ) u_sync_delay (
    .clk (Clk),
    .rst (Reset),
    .ce  (pix_ce_r),
    .din ({hs_raw_s, vs_raw_s, blank_raw_s}),
    .dout({hs_d_s, vs_d_s, blank_d_s})
  );

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar_d_s;

  vga_sync_delay #(
    .DEPTH  (PIPE_LAT),
    .WIDTH  (3),
    .RST_VAL(3'b000)
  ) u_bar_delay (
    .clk (Clk),
    .rst (Reset),
    .ce  (pix_ce_r),
    .din (bar_index(x_r)),
    .dout(bar_d_s)
  );

  // Pick colour bars or the external colour mapper
  always_comb begin
    if (test_pattern) begin
      rgb_src_s = bar_color(bar_d_s);
    end else begin
      rgb_src_s = {Red_in, Green_in, Blue_in};
    end
  end
`else
  assign rgb_src_s = {Red_in, Green_in, Blue_in};
`endif

  // Output stage: sync, blank and blank-gated colour all land on the same strobe
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hs_r    <= 1'b1;
      vs_r    <= 1'b1;
      blank_r <= 1'b0;
      rgb_r   <= 24'h000000;
    end else if (pix_ce_r) begin
      hs_r    <= hs_d_s;
      vs_r    <= vs_d_s;
      blank_r <= blank_d_s;
      if (blank_d_s) begin
        rgb_r <= rgb_src_s;
      end else begin
        rgb_r <= 24'h000000;
      end
    end
  end

  assign pix_ce      = pix_ce_r;
  assign DrawX       = x_r;
  assign DrawY       = y_r;
  assign frame_tick  = frame_tick_r;
  assign VGA_CLK     = vga_clk_r;
  assign VGA_HS      = hs_r;
  assign VGA_VS      = vs_r;
  assign VGA_BLANK_N = blank_r;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = rgb_r.r;
  assign VGA_G       = rgb_r.g;
  assign VGA_B       = rgb_r.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance (PIPE_LAT=0) checked with
// directed timing points, and a shrunken-raster instance (PIPE_LAT=2) whose
// pin values are predicted per pixel into a queue and checked by a monitor.
module tb_vga_timing_gen;

  // Small raster for dut_b: H 8/2/3/3 (16), V 6/2/2/3 (13)
  localparam int BH_T    = 16;
  localparam int BV_T    = 13;
  localparam int B_LAT   = 2;
  localparam int B_FRAME = BH_T * BV_T;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       bn;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pins_t;

  localparam pins_t RST_PINS = {1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [7:0] red_a, grn_a, blu_a, red_b, grn_b, blu_b;
  logic       pix_ce_a, tick_a, vclk_a, hs_a, vs_a, bn_a, sn_a;
  logic       pix_ce_b, tick_b, vclk_b, hs_b, vs_b, bn_b, sn_b;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;

  int    tests = 0;
  int    fails = 0;
  int    fail_prints = 0;
  pins_t sb_q[$];
  pins_t cur = RST_PINS;
  logic  mon_en = 1'b0;
  logic  strobe_prev = 1'b0;

  vga_timing_gen #(.PIX_DIV(2), .PIPE_LAT(0)) dut_a (
    .Clk(clk), .Reset(rst_a),
`ifdef VGA_TEST_PATTERN_EN
    .test_pattern(1'b0),
`endif
    .Red_in(red_a), .Green_in(grn_a), .Blue_in(blu_a),
    .pix_ce(pix_ce_a), .DrawX(x_a), .DrawY(y_a), .frame_tick(tick_a),
    .VGA_CLK(vclk_a), .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_BLANK_N(bn_a),
    .VGA_SYNC_N(sn_a), .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .PIX_DIV(2), .PIPE_LAT(B_LAT)
  ) dut_b (
    .Clk(clk), .Reset(rst_b),
`ifdef VGA_TEST_PATTERN_EN
    .test_pattern(1'b0),
`endif
    .Red_in(red_b), .Green_in(grn_b), .Blue_in(blu_b),
    .pix_ce(pix_ce_b), .DrawX(x_b), .DrawY(y_b), .frame_tick(tick_b),
    .VGA_CLK(vclk_b), .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_BLANK_N(bn_b),
    .VGA_SYNC_N(sn_b), .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fail_prints < 40) begin
        $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        fail_prints++;
      end
    end
  endtask

  // Pixel-period index k -> raster position of the small raster
  function automatic int bx(input int k);
    return k % BH_T;
  endfunction
  function automatic int by(input int k);
    return (k / BH_T) % BV_T;
  endfunction

  // Colour the bench feeds for pixel j (FF throughout vertical blank)
  function automatic logic [7:0] red_for(input int j);
    return (by(j) >= 6) ? 8'hFF : 8'(bx(j));
  endfunction
  function automatic logic [7:0] grn_for(input int j);
    return 8'(~bx(j));
  endfunction
  function automatic logic [7:0] blu_for(input int j);
    return 8'(by(j) + 64);
  endfunction

  // Pins expected after the strobe of pixel period k: pixel k-2 shows up
  function automatic pins_t exp_pins(input int k);
    pins_t p;
    int    j, x, y;
    if (k < B_LAT) return RST_PINS;
    j = k - B_LAT;
    x = bx(j);
    y = by(j);
    p.hs = !(x >= 10 && x < 13);
    p.vs = !(y >= 8 && y < 10);
    p.bn = (x < 8) && (y < 6);
    p.r  = p.bn ? red_for(j) : 8'h00;
    p.g  = p.bn ? grn_for(j) : 8'h00;
    p.b  = p.bn ? blu_for(j) : 8'h00;
    return p;
  endfunction

  // Monitor for dut_b: after each strobe the pins take the next queued value and hold it
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (strobe_prev) begin
          if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL b_sb_underflow: strobe seen, expected-value queue empty");
          end else begin
            cur = sb_q.pop_front();
          end
        end
        check("b_hs", 32'(hs_b), 32'(cur.hs));
        check("b_vs", 32'(vs_b), 32'(cur.vs));
        check("b_blank_n", 32'(bn_b), 32'(cur.bn));
        check("b_r", 32'(r_b), 32'(cur.r));
        check("b_g", 32'(g_b), 32'(cur.g));
        check("b_b", 32'(b_b), 32'(cur.b));
        check("b_sync_n", 32'(sn_b), 0);
        strobe_prev = pix_ce_b;
      end
    end
  end

  // Stimulus for dut_b: two frames; each strobe pushes the predicted pins
  task automatic run_b();
    int k = 0;
    int idle = 0;
    int ticks = 0;
    while (k < 2 * B_FRAME && idle < 8) begin
      @(negedge clk);
      if (tick_b) ticks++;
      if (pix_ce_b) begin
        idle = 0;
        check("b_drawx", 32'(x_b), bx(k));
        check("b_drawy", 32'(y_b), by(k));
        check("b_tick", 32'(tick_b), 32'(bx(k) == 15 && by(k) == 5));
        if (k >= B_LAT) begin
          red_b = red_for(k - B_LAT);
          grn_b = grn_for(k - B_LAT);
          blu_b = blu_for(k - B_LAT);
        end else begin
          red_b = 8'h00;
          grn_b = 8'h00;
          blu_b = 8'h00;
        end
        sb_q.push_back(exp_pins(k));
        k++;
      end else begin
        idle++;
        check("b_tick_idle", 32'(tick_b), 0);
      end
    end
    check("b_pixels", k, 2 * B_FRAME);
    check("b_frame_ticks", ticks, 2);
    @(negedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    check("b_sb_empty", sb_q.size(), 0);
  endtask

  // Observe dut_a for one line after a reset release (n = negedges since release)
  task automatic measure_a(output int first_low, output int low_len,
                           output int wrap_n, output int max_x);
    int prev_x = 0;
    bit done = 1'b0;
    first_low = 0;
    low_len = 0;
    wrap_n = 0;
    max_x = 0;
    for (int n = 1; n <= 1700; n++) begin
      @(negedge clk);
      if (n <= 8) begin
        check("a_pix_ce", 32'(pix_ce_a), 32'(n >= 3 && n % 2 == 1));
        check("a_vga_clk", 32'(vclk_a), 32'(n % 2 == 0));
      end
      if (n == 3 || n == 4 || n == 1283 || n == 1284) begin
        check("a_blank_n_edge", 32'(bn_a), 32'(n == 4 || n == 1283));
        check("a_red_edge", 32'(r_a), (n == 4 || n == 1283) ? 32'hA5 : 32'h0);
        check("a_grn_edge", 32'(g_a), (n == 4 || n == 1283) ? 32'h3C : 32'h0);
      end
      if (n == 1602) check("a_drawy_after_wrap", 32'(y_a), 1);
      if (int'(x_a) > max_x) max_x = int'(x_a);
      if (x_a == 10'd0 && prev_x == 799 && wrap_n == 0) wrap_n = n;
      prev_x = int'(x_a);
      if (hs_a == 1'b0) begin
        if (first_low == 0) first_low = n;
        if (!done) low_len++;
      end else if (first_low != 0) begin
        done = 1'b1;
      end
    end
  endtask

  // Directed checks on dut_a, including a reset in the middle of an HS pulse
  task automatic run_a();
    int fl, ll, wn, mx;
    int guard = 0;
    measure_a(fl, ll, wn, mx);
    check("a_hs_first_low", fl, 1316);
    check("a_hs_low_len", ll, 192);
    check("a_wrap_n", wn, 1602);
    check("a_max_drawx", mx, 799);
    check("a_sync_n", 32'(sn_a), 0);
    while (x_a != 10'd700 && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    check("a_reach_x700", 32'(x_a), 700);
    check("a_hs_low_at_700", 32'(hs_a), 0);
    #1 rst_a = 1'b1;
    #1;
    check("a_rst_drawx", 32'(x_a), 0);
    check("a_rst_drawy", 32'(y_a), 0);
    check("a_rst_hs", 32'(hs_a), 1);
    check("a_rst_vs", 32'(vs_a), 1);
    check("a_rst_blank_n", 32'(bn_a), 0);
    check("a_rst_red", 32'(r_a), 0);
    check("a_rst_pix_ce", 32'(pix_ce_a), 0);
    check("a_rst_vga_clk", 32'(vclk_a), 0);
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b0;
    measure_a(fl, ll, wn, mx);
    check("a_hs_first_low_after_rst", fl, 1316);
    check("a_hs_low_len_after_rst", ll, 192);
    check("a_wrap_n_after_rst", wn, 1602);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    red_a = 8'hA5;
    grn_a = 8'h3C;
    blu_a = 8'h0F;
    red_b = 8'h00;
    grn_b = 8'h00;
    blu_b = 8'h00;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_drawx", 32'(x_a), 0);
    check("rst_drawy", 32'(y_a), 0);
    check("rst_hs", 32'(hs_a), 1);
    check("rst_vs", 32'(vs_a), 1);
    check("rst_blank_n", 32'(bn_a), 0);
    check("rst_rgb", {8'h00, r_a, g_a, b_a}, 0);
    check("rst_pix_ce", 32'(pix_ce_a), 0);
    check("rst_tick", 32'(tick_a), 0);
    check("rst_vga_clk", 32'(vclk_a), 0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    fork
      run_a();
      run_b();
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded 1 ms");
    $fatal(1);
  end

endmodule
